// File: rtl/tipi_rpi_shifter_pkg.sv
// -----------------------------------------------------------------------------
// tipi_pkg
// Shared definitions for the RPi-side TIPI mailbox shifter:
//   - register-select codes carried on r_reg during a frame
//   - FSM state encoding for the frame sequencer
//   - default mailbox register width
//   - helper that classifies a select code as a write (RD/RC) frame
// -----------------------------------------------------------------------------
package tipi_pkg;

   localparam int TIPI_WIDTH = 8;

   // Register select, sampled when the RPi drops r_le
   localparam logic [1:0] SEL_TD = 2'b00;   // read TI data latch
   localparam logic [1:0] SEL_TC = 2'b01;   // read TI control latch
   localparam logic [1:0] SEL_RD = 2'b10;   // write TI-readable data
   localparam logic [1:0] SEL_RC = 2'b11;   // write TI-readable control

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_COMMIT = 2'd3
   } tipi_state_e;

   // RD and RC are the only registers the RPi writes; both have bit 1 set
   function automatic logic sel_is_write(input logic [1:0] sel);
      return sel[1];
   endfunction

endpackage

// File: rtl/tipi_rpi_shifter_sync.sv
// -----------------------------------------------------------------------------
// tipi_sync
// Multi-bit synchroniser for signals that are asynchronous to clk.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage to 0
//   d      : asynchronous input bus (W bits)
//   q      : synchronised output bus
// Parameters:
//   W       : bus width
//   STAGES  : flops in the synchroniser chain (must be 2 or more)
//   QUALIFY : when set, q is a snapshot that only takes a new value once two
//             consecutive synchronised samples agree. This filters a bus that
//             is caught mid-update by its writer, so q never shows a mix of
//             old and new bits.
// -----------------------------------------------------------------------------
module tipi_sync #(
   parameter int W       = 1,
   parameter int STAGES  = 2,
   parameter bit QUALIFY = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain_q [STAGES];
   logic [W-1:0] chain_d [STAGES];
   logic [W-1:0] prev_q;
   logic [W-1:0] prev_d;
   logic [W-1:0] snap_q;
   logic [W-1:0] snap_d;

   always_comb begin
      chain_d[0] = d;
      for (int i = 1; i < STAGES; i++) begin
         chain_d[i] = chain_q[i-1];
      end
      prev_d = chain_q[STAGES-1];
      snap_d = snap_q;
      // Accept the synced value only when it matched the previous sample
      if (chain_q[STAGES-1] == prev_q) begin
         snap_d = prev_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
         prev_q <= '0;
         snap_q <= '0;
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= chain_d[i];
         end
         prev_q <= prev_d;
         snap_q <= snap_d;
      end
   end

   assign q = QUALIFY ? snap_q : chain_q[STAGES-1];

endmodule

// File: rtl/tipi_rpi_shifter.sv
// -----------------------------------------------------------------------------
// tipi_rpi_shifter
// Raspberry-Pi-side endpoint of the TIPI mailbox registers. The RPi runs
// framed transfers over four GPIOs; a frame reads TD/TC out serially
// (MSB first) or writes a byte into RD/RC for the TI to read.
// Ports:
//   clk       : board clock (50 MHz)
//   rst_n     : asynchronous active-low reset
//   r_clk     : RPi shift clock (async), data moves on its rising edge
//   r_le      : RPi frame strobe (async), low while a frame is active
//   r_reg     : register select, captured at the start of a frame
//   r_din     : RPi serial write data
//   r_dout    : serial read data to the RPi
//   td, tc    : TI-written data/control latches (async to clk)
//   rd, rc    : TI-readable data/control registers
//   frame_err : one-clock pulse when a write frame is discarded
// Timing: the first read bit appears SYNC_STAGES+2 clocks after r_le falls,
// each later bit SYNC_STAGES+1 clocks after an r_clk rise, so the RPi must
// hold each r_clk level for at least SYNC_STAGES+2 clocks.
// -----------------------------------------------------------------------------
module tipi_rpi_shifter
   import tipi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WIDTH       = TIPI_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r_clk,
   input  logic             r_le,
   input  logic [1:0]       r_reg,
   input  logic             r_din,
   output logic             r_dout,
   input  logic [WIDTH-1:0] td,
   input  logic [WIDTH-1:0] tc,
   output logic [WIDTH-1:0] rd,
   output logic [WIDTH-1:0] rc,
   output logic             frame_err
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   // ---------------------------------------------------------------------------
   // Input synchronisation
   // ---------------------------------------------------------------------------
   logic [4:0]       ctrl_raw;
   logic [4:0]       ctrl_s;
   logic             s_clk;
   logic             s_le;
   logic             s_din;
   logic [1:0]       s_reg;
   logic [WIDTH-1:0] td_snap;
   logic [WIDTH-1:0] tc_snap;

   // GPIO lines share one chain so r_din/r_reg stay aligned with r_clk/r_le
   assign ctrl_raw = {r_reg, r_din, r_le, r_clk};

   tipi_sync #(
      .W       (5),
      .STAGES  (SYNC_STAGES),
      .QUALIFY (1'b0)
   ) u_sync_ctrl (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ctrl_raw),
      .q     (ctrl_s)
   );

   assign s_clk = ctrl_s[0];
   assign s_le  = ctrl_s[1];
   assign s_din = ctrl_s[2];
   assign s_reg = ctrl_s[4:3];

   // td and tc are qualified independently so activity on one latch never
   // stalls the snapshot of the other
   tipi_sync #(
      .W       (WIDTH),
      .STAGES  (SYNC_STAGES),
      .QUALIFY (1'b1)
   ) u_sync_td (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (td),
      .q     (td_snap)
   );

   tipi_sync #(
      .W       (WIDTH),
      .STAGES  (SYNC_STAGES),
      .QUALIFY (1'b1)
   ) u_sync_tc (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tc),
      .q     (tc_snap)
   );

   // ---------------------------------------------------------------------------
   // Edge detection and frame sequencer
   // ---------------------------------------------------------------------------
   tipi_state_e      state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovr_q, ovr_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic [WIDTH-1:0] rc_q, rc_d;
   logic             ferr_q, ferr_d;
   logic             clk_prev_q, clk_prev_d;
   logic             le_prev_q, le_prev_d;

   logic             clk_rise;
   logic             le_fall;
   logic             le_rise;
   logic             wr_frame;
   logic             fill_bit;

   assign clk_rise = s_clk & ~clk_prev_q;
   assign le_fall  = ~s_le & le_prev_q;
   assign le_rise  = s_le & ~le_prev_q;
   assign wr_frame = sel_is_write(sel_q);
   // Read frames shift zeros in behind the outgoing byte
   assign fill_bit = wr_frame ? s_din : 1'b0;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      ovr_d      = ovr_q;
      rd_d       = rd_q;
      rc_d       = rc_q;
      ferr_d     = 1'b0;
      clk_prev_d = s_clk;
      le_prev_d  = s_le;

      case (state_q)
         ST_IDLE: begin
            if (le_fall) begin
               sel_d   = s_reg;
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            if (wr_frame) begin
               shift_d = '0;
            end else if (sel_q == SEL_TD) begin
               shift_d = td_snap;
            end else begin
               shift_d = tc_snap;
            end
            cnt_d   = '0;
            ovr_d   = 1'b0;
            state_d = ST_SHIFT;
         end

         ST_SHIFT: begin
            // A shift edge coinciding with the closing r_le edge is applied
            // first, so COMMIT sees the final count
            if (clk_rise) begin
               shift_d = {shift_q[WIDTH-2:0], fill_bit};
               if (cnt_q == CNT_W'(WIDTH)) begin
                  ovr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            if (le_rise) begin
               state_d = ST_COMMIT;
            end
         end

         ST_COMMIT: begin
            if (wr_frame) begin
               if ((cnt_q == CNT_W'(WIDTH)) && !ovr_q) begin
                  if (sel_q == SEL_RD) begin
                     rd_d = shift_q;
                  end else begin
                     rc_d = shift_q;
                  end
               end else begin
                  ferr_d = 1'b1;
               end
            end
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= SEL_TD;
         shift_q    <= '0;
         cnt_q      <= '0;
         ovr_q      <= 1'b0;
         rd_q       <= '0;
         rc_q       <= '0;
         ferr_q     <= 1'b0;
         clk_prev_q <= 1'b0;
         le_prev_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         ovr_q      <= ovr_d;
         rd_q       <= rd_d;
         rc_q       <= rc_d;
         ferr_q     <= ferr_d;
         clk_prev_q <= clk_prev_d;
         le_prev_q  <= le_prev_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign r_dout    = (state_q == ST_SHIFT) && !wr_frame && shift_q[WIDTH-1];
   assign rd        = rd_q;
   assign rc        = rc_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_tipi_rpi_shifter.sv
module tb_tipi_rpi_shifter;
   import tipi_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         r_clk;
   logic         r_le;
   logic [1:0]   r_reg;
   logic         r_din;
   logic         r_dout;
   logic [W-1:0] td;
   logic [W-1:0] tc;
   logic [W-1:0] rd;
   logic [W-1:0] rc;
   logic         frame_err;

   int n_checks = 0;
   int n_errors = 0;
   int err_pulses = 0;

   tipi_rpi_shifter #(
      .SYNC_STAGES (2),
      .WIDTH       (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .r_clk     (r_clk),
      .r_le      (r_le),
      .r_reg     (r_reg),
      .r_din     (r_din),
      .r_dout    (r_dout),
      .td        (td),
      .tc        (tc),
      .rd        (rd),
      .rc        (rc),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (frame_err) err_pulses <= err_pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Open a frame and clock n bits from 'bits' MSB first; optionally raise r_le
   task automatic write_frame(input logic [1:0] sel, input logic [15:0] bits,
                              input int n, input bit close);
      @(negedge clk);
      r_reg = sel;
      r_le  = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         r_din = bits[n-1-i];
         repeat (3) @(negedge clk);
         r_clk = 1'b1;
         repeat (6) @(negedge clk);
         r_clk = 1'b0;
         repeat (6) @(negedge clk);
      end
      if (close) r_le = 1'b1;
   endtask

   // Read frame: sample r_dout before the first pulse and after each shift
   task automatic read_frame(input logic [1:0] sel, output logic [W-1:0] val);
      val = '0;
      @(negedge clk);
      r_reg = sel;
      r_le  = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < W; i++) begin
         val   = {val[W-2:0], r_dout};
         r_clk = 1'b1;
         repeat (6) @(negedge clk);
         r_clk = 1'b0;
         repeat (6) @(negedge clk);
      end
      r_le = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] td_seq;
      int           e0;
      bit           tog_en;

      rst_n = 1'b0;
      r_clk = 1'b0;
      r_le  = 1'b1;
      r_reg = 2'b00;
      r_din = 1'b0;
      td    = 8'h00;
      tc    = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_rd", rd, 8'h00);
      chk("rst_rc", rc, 8'h00);
      chk("rst_dout", r_dout, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Give rd a non-zero value so the reset check below means something
      write_frame(SEL_RD, 16'h003F, 8, 1'b1);
      repeat (6) @(negedge clk);
      chk("pre_rd", rd, 8'h3F);

      // Reset in the middle of a write frame
      write_frame(SEL_RD, 16'h000F, 4, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midrst_rd", rd, 8'h00);
      chk("midrst_rc", rc, 8'h00);
      chk("midrst_dout", r_dout, 1'b0);
      chk("midrst_state", dut.state_q, ST_IDLE);
      r_le  = 1'b1;
      r_clk = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      e0 = err_pulses;
      write_frame(SEL_RD, 16'h00A5, 8, 1'b1);
      repeat (6) @(negedge clk);
      chk("rd_after_rst", rd, 8'hA5);
      chk("rc_after_rst", rc, 8'h00);
      chk("ferr_after_rst", err_pulses - e0, 0);

      // Read TD = 0x3C: 0,0,1,1,1,1,0,0
      td = 8'h3C;
      repeat (10) @(negedge clk);
      e0 = err_pulses;
      read_frame(SEL_TD, v);
      td_seq = 8'b0011_1100;
      for (int i = 0; i < W; i++) begin
         chk($sformatf("td_bit%0d", i), v[W-1-i], td_seq[W-1-i]);
      end
      chk("td_byte", v, 8'h3C);
      chk("td_rd_hold", rd, 8'hA5);
      chk("td_rc_hold", rc, 8'h00);
      chk("td_no_ferr", err_pulses - e0, 0);

      // Read TC to exercise the other read source
      tc = 8'h5A;
      repeat (10) @(negedge clk);
      read_frame(SEL_TC, v);
      chk("tc_byte", v, 8'h5A);

      // Write RC = 0x96, visible within SYNC_STAGES+3 clocks of r_le rise
      e0 = err_pulses;
      write_frame(SEL_RC, 16'h0096, 8, 1'b1);
      repeat (5) @(negedge clk);
      chk("rc_write", rc, 8'h96);
      chk("rc_rd_hold", rd, 8'hA5);
      repeat (3) @(negedge clk);
      chk("rc_no_ferr", err_pulses - e0, 0);

      // Short (5) and overrun (9) RD writes are discarded
      e0 = err_pulses;
      write_frame(SEL_RD, 16'h001F, 5, 1'b1);
      repeat (8) @(negedge clk);
      chk("short_rd", rd, 8'hA5);
      chk("short_ferr", err_pulses - e0, 1);
      write_frame(SEL_RD, 16'h01FF, 9, 1'b1);
      repeat (8) @(negedge clk);
      chk("ovr_rd", rd, 8'hA5);
      chk("ovr_ferr_total", err_pulses - e0, 2);
      chk("ovr_rc", rc, 8'h96);

      // td changes after LOAD: the frame still returns the loaded byte
      td = 8'h00;
      repeat (10) @(negedge clk);
      fork
         read_frame(SEL_TD, v);
         begin
            repeat (12) @(negedge clk);
            td = 8'hFF;
         end
      join
      chk("midchg_byte", v, 8'h00);
      repeat (10) @(negedge clk);
      read_frame(SEL_TD, v);
      chk("midchg_next", v, 8'hFF);

      // td toggles every clock: snapshot holds the last settled 0xFF
      tog_en = 1'b1;
      fork
         begin
            int k;
            k = 0;
            while (tog_en) begin
               @(negedge clk);
               td = (k % 2 == 0) ? 8'h55 : 8'hAA;
               k++;
            end
         end
         begin
            read_frame(SEL_TD, v);
            tog_en = 1'b0;
         end
      join
      chk("toggle_hold", v, 8'hFF);
      td = 8'h81;
      repeat (10) @(negedge clk);
      read_frame(SEL_TD, v);
      chk("settle_byte", v, 8'h81);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tipi_rpi_shifter.md
Name: tipi_rpi_shifter

Overview:
- Raspberry-Pi-side endpoint of the TIPI mailbox registers.
- Serialises the TI-written data/control latches (TD/TC) out to the RPi over a 4-wire GPIO shift protocol.
- Deserialises RPi-written bytes into the TI-readable data/control registers (RD/RC) that drive the TI-side bus transmitters.
- All RPi GPIO inputs are asynchronous; everything runs on the board clock.

Parameters:
- SYNC_STAGES, 2, flops in each input synchroniser chain (minimum 2).
- WIDTH, 8, register width in bits.

Ports:
- clk  input  1  board clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- r_clk  input  1  RPi shift clock, async; data moves on its rising edge.
- r_le  input  1  RPi frame strobe, async; low = frame active.
- r_reg  input  2  register select, sampled at frame start: 00=TD, 01=TC, 10=RD, 11=RC.
- r_din  input  1  RPi serial data in (write frames).
- r_dout  output  1  serial data to RPi (read frames).
- td  input  WIDTH  TI-written data latch (0x5fff), async to clk.
- tc  input  WIDTH  TI-written control latch (0x5ffd), async to clk.
- rd  output  WIDTH  TI-readable data (0x5ffb) to bus transmitter.
- rc  output  WIDTH  TI-readable control (0x5ff9) to bus transmitter.
- frame_err  output  1  one-clk pulse when a write frame is aborted.

Behaviour:
- Reset (rst_n low, async):
  - rd=0, rc=0, r_dout=0, frame_err=0.
  - Shift register and bit counter cleared; FSM to IDLE.
  - Sync chains cleared; previous-sample registers for edge detection cleared.
- Input synchronisation:
  - r_clk, r_le, r_din, r_reg pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised r_clk and r_le against their previous samples.
  - td/tc pass through SYNC_STAGES flops plus a stability stage. A snapshot value updates only when two consecutive synced samples are equal, so a mid-write TI change never yields a mixed byte.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: r_dout=0. A synced r_le falling edge latches r_reg into sel, then goes to LOAD.
  - LOAD (1 clk):
    - sel=TD/TC: the shift register loads from the TD/TC snapshot.
    - sel=RD/RC: the shift register clears.
    - Counter=0. Goes to SHIFT.
  - SHIFT:
    - Read frame (sel TD/TC): r_dout = shift[WIDTH-1] at all times. Each synced r_clk rising edge shifts left with 0 fill, counter+1.
    - Write frame (sel RD/RC): each synced r_clk rising edge shifts left and inserts synced r_din into bit 0, counter+1.
    - Counter saturates at WIDTH. Further edges still shift, but the counter holds, so the frame is marked overrun.
    - A synced r_le rising edge goes to COMMIT.
  - COMMIT (1 clk):
    - Write frame with counter==WIDTH and no overrun: rd or rc <= shift register. The target is visible the next clk and holds until the next valid commit.
    - Write frame with counter!=WIDTH or overrun: no register update, frame_err pulses 1 clk.
    - Read frame: no side effects, and no error regardless of count.
    - Goes to IDLE.
- Latency: r_dout's first bit is valid SYNC_STAGES+2 clks after the r_le fall pin edge. Each subsequent bit is valid SYNC_STAGES+1 clks after the r_clk rise pin edge. The RPi must hold each r_clk level ≥ SYNC_STAGES+2 clks.
- Simultaneous events:
  - r_clk and r_le edges detected in the same clk in SHIFT: the shift is applied first, then the FSM goes to COMMIT with the updated count.
  - An r_le fall while not in IDLE is ignored.
- rd/rc change only in COMMIT; they are never glitched by shifting.

Decomposition:
- Shared package tipi_pkg:
  - register-select constants (SEL_TD=2'b00, SEL_TC=2'b01, SEL_RD=2'b10, SEL_RC=2'b11);
  - FSM state encoding;
  - default WIDTH.
- One sub-module, tipi_sync: a parameterised multi-bit synchroniser with optional stable-sample qualify. It is instantiated for the GPIO control lines and for td/tc.

Test Plan:
- Reset: assert rst_n low mid-frame after 4 write bits → rd=0, rc=0, r_dout=0, FSM IDLE. A following full RD write of 0xA5 commits correctly.
- Read TD: td=0x3C stable, frame r_reg=00 with 8 r_clk pulses → r_dout sequence 0,0,1,1,1,1,0,0 (MSB first); rd/rc unchanged.
- Write RC: r_reg=11, r_din bits 1,0,0,1,0,1,1,0 → after r_le rise, rc=0x96 within SYNC_STAGES+3 clks; rd unchanged; frame_err=0.
- Short/overrun write: RD frame with 5 pulses, then an RD frame with 9 pulses → rd keeps the prior value; frame_err pulses once per frame (2 total).
- TI change mid-read: td goes 0x00→0xFF after LOAD → the shifted byte is 0x00 throughout. The next frame reads 0xFF.
- Snapshot stability: td toggles 0x55/0xAA every clk, then settles at 0x81 → the frame read after settling returns 0x81, never a mixed value.
